// File: rtl/multicycle_control_pkg.sv
// ============================================================================
//  Module      : multicycle_control_pkg
//  Description : Shared state encoding, opcode and ALU code constants for the
//                multicycle RISC-V control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

    typedef logic [3:0] state_t;

    localparam state_t c_st_fetch    = 4'd0;
    localparam state_t c_st_decode   = 4'd1;
    localparam state_t c_st_memadr   = 4'd2;
    localparam state_t c_st_memread  = 4'd3;
    localparam state_t c_st_memwb    = 4'd4;
    localparam state_t c_st_memwrite = 4'd5;
    localparam state_t c_st_exec_r   = 4'd6;
    localparam state_t c_st_exec_i   = 4'd7;
    localparam state_t c_st_aluwb    = 4'd8;
    localparam state_t c_st_branch   = 4'd9;
    localparam state_t c_st_jal      = 4'd10;
    localparam state_t c_st_illegal  = 4'd11;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_and  = 4'b0010;
    localparam logic [3:0] c_alu_or   = 4'b0011;
    localparam logic [3:0] c_alu_xor  = 4'b0100;
    localparam logic [3:0] c_alu_slt  = 4'b0101;
    localparam logic [3:0] c_alu_sll  = 4'b0110;
    localparam logic [3:0] c_alu_srl  = 4'b0111;
    localparam logic [3:0] c_alu_sra  = 4'b1000;
    localparam logic [3:0] c_alu_sltu = 4'b1001;

    // ALUOp classes handed from the FSM to the ALU decoder
    localparam logic [1:0] c_aluop_add    = 2'b00;
    localparam logic [1:0] c_aluop_branch = 2'b01;
    localparam logic [1:0] c_aluop_func   = 2'b10;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            c_op_store:  imm_src_of = 2'b01;
            c_op_branch: imm_src_of = 2'b10;
            c_op_jal:    imm_src_of = 2'b11;
            default:     imm_src_of = 2'b00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
// ============================================================================
//  Module      : alu_decoder
//  Description : Maps ALUOp class, funct3, funct7b5 and op[5] to ALU_Control.
//                Optional macro BRANCH_EXT_EN selects sltu for bltu/bgeu.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import multicycle_control_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [1:0]           i_alu_op,
    input  logic [2:0]           i_funct3,
    input  logic                 i_funct7b5,
    input  logic                 i_op5,
    output logic [ALUCTRL_W-1:0] o_alu_control
);

    logic [3:0] w_code;

    always_comb begin
        w_code = c_alu_add;
        case (i_alu_op)
            c_aluop_branch: begin
`ifdef BRANCH_EXT_EN
                w_code = (i_funct3[2:1] == 2'b11) ? c_alu_sltu : c_alu_sub;
`else
                w_code = c_alu_sub;
`endif
            end
            c_aluop_func: begin
                case (i_funct3)
                    // Only R-type (op[5]=1) may subtract; I-type bit 30 is immediate data
                    3'b000:  w_code = (i_op5 && i_funct7b5) ? c_alu_sub : c_alu_add;
                    3'b001:  w_code = c_alu_sll;
                    3'b010:  w_code = c_alu_slt;
                    3'b011:  w_code = c_alu_sltu;
                    3'b100:  w_code = c_alu_xor;
                    3'b101:  w_code = i_funct7b5 ? c_alu_sra : c_alu_srl;
                    3'b110:  w_code = c_alu_or;
                    default: w_code = c_alu_and;
                endcase
            end
            default: w_code = c_alu_add;
        endcase
    end

    assign o_alu_control = ALUCTRL_W'(w_code);

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
//  Module      : multicycle_control
//  Description : Multicycle RISC-V control FSM with retired-instruction count.
//                Optional macro BRANCH_EXT_EN adds bne/blt/bge/bltu/bgeu.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 Negative,
    input  logic                 Overflow,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALU_Control,
    output logic [3:0]           state_dbg,
    output logic [CNT_W-1:0]     instr_retired,
    output logic                 illegal
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    logic [1:0]       w_alu_op;
    logic             w_br_taken;
    logic             w_br_illegal;
    logic             w_unused_flags;

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_fetch:    if (mem_ready) w_next = c_st_decode;
            c_st_decode: begin
                case (op)
                    c_op_load,
                    c_op_store:  w_next = c_st_memadr;
                    c_op_rtype:  w_next = c_st_exec_r;
                    c_op_itype:  w_next = c_st_exec_i;
                    c_op_branch: w_next = c_st_branch;
                    c_op_jal:    w_next = c_st_jal;
                    default:     w_next = c_st_illegal;
                endcase
            end
            c_st_memadr:   w_next = op[5] ? c_st_memwrite : c_st_memread;
            c_st_memread:  if (mem_ready) w_next = c_st_memwb;
            c_st_memwrite: if (mem_ready) w_next = c_st_fetch;
            c_st_exec_r,
            c_st_exec_i,
            c_st_jal:      w_next = c_st_aluwb;
            default:       w_next = c_st_fetch;
        endcase
    end

    // bltu/bgeu run sltu in the ALU, so Zero=0 means "less than unsigned"
    always_comb begin
        w_br_taken   = 1'b0;
        w_br_illegal = 1'b0;
        case (funct3)
            3'b000:  w_br_taken = Zero;
`ifdef BRANCH_EXT_EN
            3'b001:  w_br_taken = ~Zero;
            3'b100:  w_br_taken = Negative ^ Overflow;
            3'b101:  w_br_taken = ~(Negative ^ Overflow);
            3'b110:  w_br_taken = ~Zero;
            3'b111:  w_br_taken = Zero;
`endif
            default: w_br_illegal = 1'b1;
        endcase
    end

    assign w_unused_flags = Negative ^ Overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_fetch;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state != c_st_fetch) && (w_next == c_st_fetch))
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    // FETCH enables are masked by reset so they drop the instant reset rises
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        w_alu_op  = c_aluop_add;
        illegal   = 1'b0;
        case (r_state)
            c_st_fetch: begin
                IRWrite   = mem_ready & ~reset;
                PCWrite   = mem_ready & ~reset;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            c_st_decode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            c_st_memadr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            c_st_memread:  AdrSrc = 1'b1;
            c_st_memwb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            c_st_memwrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            c_st_exec_r: begin
                ALUSrcA  = 2'b10;
                w_alu_op = c_aluop_func;
            end
            c_st_exec_i: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = c_aluop_func;
            end
            c_st_aluwb:    RegWrite = 1'b1;
            c_st_branch: begin
                ALUSrcA  = 2'b10;
                w_alu_op = c_aluop_branch;
                PCWrite  = w_br_taken;
                illegal  = w_br_illegal;
            end
            c_st_jal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            c_st_illegal:  illegal = 1'b1;
            default: ;
        endcase
    end

    alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (ALU_Control)
    );

    assign ImmSrc        = imm_src_of(op);
    assign state_dbg     = r_state;
    assign instr_retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero, Negative, Overflow;
    logic        mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0]  ALU_Control;
    logic [3:0]  state_dbg;
    logic [31:0] instr_retired;
    logic        illegal;

    int n_checks    = 0;
    int n_errors    = 0;
    int exp_retired = 0;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] ctrl;
        logic [3:0] st;
    } alu_vec_t;

    alu_vec_t vecs [9];

    multicycle_control #(
        .ALUCTRL_W (4),
        .CNT_W     (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .Zero          (Zero),
        .Negative      (Negative),
        .Overflow      (Overflow),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .AdrSrc        (AdrSrc),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ImmSrc        (ImmSrc),
        .ALU_Control   (ALU_Control),
        .state_dbg     (state_dbg),
        .instr_retired (instr_retired),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH (posedge+1, mem_ready=1); ends in the state after DECODE
    task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        #1;
        check("fetch_state", 32'(state_dbg), 32'd0);
        check("fetch_irwrite", 32'(IRWrite), 32'd1);
        step();
        check("decode_state", 32'(state_dbg), 32'd1);
        check("decode_srca", 32'(ALUSrcA), 32'd1);
        check("decode_srcb", 32'(ALUSrcB), 32'd1);
        check("decode_alu", 32'(ALU_Control), 32'd0);
        step();
    endtask

    task automatic retire_check();
        exp_retired++;
        check("retire_state", 32'(state_dbg), 32'd0);
        check("retired", instr_retired, 32'(exp_retired));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{7'b0110011, 3'b000, 1'b1, 4'b0001, 4'd6},
            '{7'b0110011, 3'b111, 1'b0, 4'b0010, 4'd6},
            '{7'b0110011, 3'b110, 1'b0, 4'b0011, 4'd6},
            '{7'b0010011, 3'b100, 1'b0, 4'b0100, 4'd7},
            '{7'b0010011, 3'b010, 1'b0, 4'b0101, 4'd7},
            '{7'b0010011, 3'b001, 1'b0, 4'b0110, 4'd7},
            '{7'b0010011, 3'b101, 1'b0, 4'b0111, 4'd7},
            '{7'b0010011, 3'b101, 1'b1, 4'b1000, 4'd7},
            '{7'b0010011, 3'b000, 1'b1, 4'b0000, 4'd7}
        };
        reset = 1'b1; mem_ready = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        Zero = 1'b0; Negative = 1'b0; Overflow = 1'b0;
        #3;
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_retired", instr_retired, 32'd0);
        check("rst_irwrite", 32'(IRWrite), 32'd0);
        check("rst_pcwrite", 32'(PCWrite), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // FETCH stall
        mem_ready = 1'b0; #1;
        check("stall_irwrite", 32'(IRWrite), 32'd0);
        check("stall_pcwrite", 32'(PCWrite), 32'd0);
        step();
        check("stall_state", 32'(state_dbg), 32'd0);
        check("stall_retired", instr_retired, 32'd0);
        mem_ready = 1'b1; #1;
        check("fetch_pcwrite", 32'(PCWrite), 32'd1);
        check("fetch_srcb", 32'(ALUSrcB), 32'd2);
        check("fetch_ressrc", 32'(ResultSrc), 32'd2);
        check("fetch_adrsrc", 32'(AdrSrc), 32'd0);

        // add x3,x1,x2
        issue(7'b0110011, 3'b000, 1'b0);
        check("add_state", 32'(state_dbg), 32'd6);
        check("add_alu", 32'(ALU_Control), 32'd0);
        check("add_regwrite_exec", 32'(RegWrite), 32'd0);
        step();
        check("add_aluwb_state", 32'(state_dbg), 32'd8);
        check("add_regwrite_wb", 32'(RegWrite), 32'd1);
        step();
        retire_check();

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].op, vecs[i].f3, vecs[i].f7);
            check("vec_state", 32'(state_dbg), 32'(vecs[i].st));
            check("vec_alu", 32'(ALU_Control), 32'(vecs[i].ctrl));
            step();
            step();
            retire_check();
        end

        // lw with three stall cycles in MEMREAD
        issue(7'b0000011, 3'b010, 1'b0);
        check("lw_memadr", 32'(state_dbg), 32'd2);
        check("lw_srca", 32'(ALUSrcA), 32'd2);
        check("lw_imm", 32'(ImmSrc), 32'd0);
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("lw_memread", 32'(state_dbg), 32'd3);
            check("lw_adrsrc", 32'(AdrSrc), 32'd1);
            mem_ready = (i == 3);
            step();
        end
        check("lw_memwb", 32'(state_dbg), 32'd4);
        check("lw_ressrc", 32'(ResultSrc), 32'd1);
        check("lw_regwrite", 32'(RegWrite), 32'd1);
        step();
        retire_check();

        // sw with one stall cycle in MEMWRITE
        issue(7'b0100011, 3'b010, 1'b0);
        check("sw_memadr", 32'(state_dbg), 32'd2);
        check("sw_imm", 32'(ImmSrc), 32'd1);
        mem_ready = 1'b0;
        step();
        check("sw_memwrite_st", 32'(state_dbg), 32'd5);
        check("sw_memwrite", 32'(MemWrite), 32'd1);
        step();
        check("sw_memwrite_hold", 32'(MemWrite), 32'd1);
        mem_ready = 1'b1;
        step();
        retire_check();

        // beq taken / not taken
        Zero = 1'b1;
        issue(7'b1100011, 3'b000, 1'b0);
        check("beq_state", 32'(state_dbg), 32'd9);
        check("beq_t_pcwrite", 32'(PCWrite), 32'd1);
        check("beq_alu", 32'(ALU_Control), 32'd1);
        check("beq_imm", 32'(ImmSrc), 32'd2);
        check("beq_illegal", 32'(illegal), 32'd0);
        step();
        retire_check();
        Zero = 1'b0;
        issue(7'b1100011, 3'b000, 1'b0);
        check("beq_nt_pcwrite", 32'(PCWrite), 32'd0);
        step();
        retire_check();

        // jal
        issue(7'b1101111, 3'b000, 1'b0);
        check("jal_state", 32'(state_dbg), 32'd10);
        check("jal_pcwrite", 32'(PCWrite), 32'd1);
        check("jal_srca", 32'(ALUSrcA), 32'd1);
        check("jal_srcb", 32'(ALUSrcB), 32'd2);
        check("jal_ressrc", 32'(ResultSrc), 32'd0);
        check("jal_imm", 32'(ImmSrc), 32'd3);
        step();
        check("jal_aluwb", 32'(state_dbg), 32'd8);
        check("jal_regwrite", 32'(RegWrite), 32'd1);
        step();
        retire_check();

        // unknown opcode
        issue(7'b1111111, 3'b000, 1'b0);
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_regwrite", 32'(RegWrite), 32'd0);
        check("ill_memwrite", 32'(MemWrite), 32'd0);
        check("ill_pcwrite", 32'(PCWrite), 32'd0);
        step();
        retire_check();
        check("ill_cleared", 32'(illegal), 32'd0);

        // blt with Negative=1, Overflow=0
        Negative = 1'b1;
        issue(7'b1100011, 3'b100, 1'b0);
`ifdef BRANCH_EXT_EN
        check("blt_pcwrite", 32'(PCWrite), 32'd1);
        check("blt_illegal", 32'(illegal), 32'd0);
`else
        check("blt_pcwrite", 32'(PCWrite), 32'd0);
        check("blt_illegal", 32'(illegal), 32'd1);
`endif
        step();
        retire_check();
        Negative = 1'b0;

        // asynchronous reset in the middle of a store
        issue(7'b0100011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        step();
        check("rst_mw_before", 32'(MemWrite), 32'd1);
        #2;
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_mw_memwrite", 32'(MemWrite), 32'd0);
        check("rst_mw_state", 32'(state_dbg), 32'd0);
        check("rst_mw_retired", instr_retired, 32'd0);
        check("rst_mw_irwrite", 32'(IRWrite), 32'd0);
        check("rst_mw_pcwrite", 32'(PCWrite), 32'd0);
        exp_retired = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("post_rst_retired", instr_retired, 32'd0);

        issue(7'b0110011, 3'b000, 1'b0);
        step();
        step();
        retire_check();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
